temporal_decoder: RTL and testbench
===================================

// Module: temporal_decoder
// PURPOSE
//  Converts race-logic (edge-time) encoded lines back to binary. Per gamma window, records for each
//  input line the cycle offset of its first active edge; no edge in the window decodes to INF.
//  Sits at the output boundary of the temporal compute fabric (after less-than-eq/min/max operators),
//  handing binary results to synchronous logic via a valid/ready interface.
// PARAMETERS
//  GAMMA_CYCLE_WIDTH  16  clock cycles per gamma window (G); legal values 2..255
//  NUM_LINES          4   number of temporal lines decoded in parallel
//  FALLING            0   0: active edge is rising (idle level 0); 1: falling (idle level 1)
//  VAL_W = $clog2(GAMMA_CYCLE_WIDTH+1)  derived localparam; width of one decoded value
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 asynchronous reset, active-high
//  gamma_start  in   1                 one-cycle pulse; that cycle is window offset t=0
//  lines_in     in   NUM_LINES         temporal lines, synchronous to clk
//  out_valid    out  1                 decoded result available
//  out_ready    in   1                 consumer accepts result when out_valid&out_ready
//  out_value    out  NUM_LINES*VAL_W   line i at [i*VAL_W +: VAL_W]; 0..G-1 edge offset, G = INF
//  out_overrun  out  1                 sticky: a completed window was dropped (buffer full)
//  busy         out  1                 window in progress
// BEHAVIOUR
//  Reset: out_valid=0, out_value=0, out_overrun=0, busy=0, FSM=IDLE, counter=0, prev samples=idle level.
//  FSM IDLE->ACTIVE on gamma_start; ACTIVE->IDLE after offset t=G-1 unless gamma_start that cycle.
//  Window counter t: 0 at gamma_start cycle, +1 per cycle, max G-1; busy=1 while ACTIVE or gamma_start.
//  Edge detect per line: active edge at t when line is at active level at t and prev sample was idle;
//   prev sample forced to idle level at t=0 (a line already active at t=0 decodes to 0).
//  First edge wins: per-line captured flag set on first edge; later edges/glitches in window ignored.
//  Line never edging in window -> value G (INF). Value width VAL_W, no saturation needed.
//  Completion: at t=G-1 (including edge in that cycle) result transfers to output buffer;
//   out_valid rises the next cycle. Latency gamma_start -> out_valid = G cycles.
//  Output buffer single entry, independent of capture regs: next window may run while held.
//  Transfer while buffer full and no handshake that cycle -> result dropped, out_overrun=1 until rst;
//   buffer keeps old value. Handshake in transfer cycle -> new result loaded, out_valid stays 1, no overrun.
//  out_value stable while out_valid=1 and out_ready=0 (no change until handshake).
//  gamma_start while ACTIVE -> window restarts at t=0, partial captures discarded, no output produced.
//  gamma_start in the cycle after t=G-1 (back-to-back windows) is legal, no idle gap required.
//  rst mid-window or with result pending -> immediate return to reset state; partial result lost.
// STRUCTURE
//  Package temporal_pkg: function val_w(G), localparam-derived INF encoding helper, typedef
//   enum logic {TD_IDLE, TD_ACTIVE} td_state_e; shared with the encoder/operators.
//  Sub-module temporal_edge_capture (one per line, generate loop): prev sample, captured flag,
//   time register; inputs clk, rst, clear, t, line; output value (INF when not captured).
//  Top: FSM, window counter, output buffer, handshake, overrun flag.
// TESTING
//  G=16, rising: gamma_start@c0, line0 rises @c3, line1 @c0, line2 never, line3 @c15
//   -> out_valid @c16, values {15,16,0,3} (line3..line0).
//  Line0 rises @t=2, falls @t=4, rises @t=6 -> value 2 (first edge only).
//  FALLING=1: line1 falls @t=7, others stay high -> line1=7, others=16.
//  out_ready=0 held; two windows complete -> first result retained, out_overrun=1; ready=1 clears valid.
//  Back-to-back windows with out_ready=1 -> results every 16 cycles, no overrun; ready pulsed
//   exactly in transfer cycle -> new value loaded, out_valid continuous.
//  gamma_start re-pulsed @t=5 -> window restarts, single output @16 cycles after 2nd pulse;
//   rst @t=9 -> all outputs 0, busy=0, no out_valid afterwards.

Source files
------------

// File: rtl/temporal_pkg.sv
// Shared types and helpers for the race-logic (temporal) fabric: window state
// encoding, decoded value width and the INF code used by encoder, operators and decoder.
package temporal_pkg;

  typedef enum logic {TD_IDLE, TD_ACTIVE} td_state_e;

  // Width needed to hold offsets 0..G-1 plus the INF code G.
  function automatic int val_w(input int g);
    return $clog2(g + 1);
  endfunction

  // A line that never edges in its window decodes to the window length itself.
  function automatic int inf_code(input int g);
    return g;
  endfunction

endpackage

// File: rtl/temporal_edge_capture.sv
// Per-line first-edge recorder: remembers the window offset of the first active edge,
// reporting INF until one is seen. The value also reflects an edge in the current cycle.
module temporal_edge_capture
  import temporal_pkg::*;
#(
  parameter int G       = 16,
  parameter bit FALLING = 1'b0,
  parameter int VAL_W   = val_w(G)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [VAL_W-1:0] t,
  input  logic             line,
  output logic [VAL_W-1:0] value
);

  localparam logic             IDLE_LVL = FALLING;
  localparam logic [VAL_W-1:0] INF      = VAL_W'(inf_code(G));

  logic             prev_q;
  logic             captured_q;
  logic [VAL_W-1:0] time_q;
  logic             prev_eff;
  logic             edge_now;

  // At t=0 the previous sample is treated as idle, so a line already active decodes to 0.
  always_comb begin
    prev_eff = clear ? IDLE_LVL : prev_q;
    edge_now = (line != IDLE_LVL) && (prev_eff == IDLE_LVL);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= IDLE_LVL;
      captured_q <= 1'b0;
      time_q     <= '0;
    end else begin
      prev_q <= line;
      if (clear) begin
        captured_q <= edge_now;
        time_q     <= t;
      end else if (!captured_q && edge_now) begin
        captured_q <= 1'b1;
        time_q     <= t;
      end
    end
  end

  // A stale flag from before the window start is ignored in the clear cycle.
  assign value = (captured_q && !clear) ? time_q : (edge_now ? t : INF);

endmodule

// File: rtl/temporal_decoder.sv
// Race-logic to binary decoder: per gamma window, captures each line's first-edge offset
// and hands the vector to synchronous logic through a single-entry valid/ready buffer.
module temporal_decoder
  import temporal_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int NUM_LINES         = 4,
  parameter bit FALLING           = 1'b0,
  localparam int VAL_W            = val_w(GAMMA_CYCLE_WIDTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gamma_start,
  input  logic [NUM_LINES-1:0]       lines_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LINES*VAL_W-1:0] out_value,
  output logic                       out_overrun,
  output logic                       busy
);

  localparam logic [VAL_W-1:0] LAST_T = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  td_state_e                  state_q, state_d;
  logic [VAL_W-1:0]           t_q, t_d, t_cur;
  logic                       last;
  logic                       hs;
  logic [NUM_LINES*VAL_W-1:0] result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TD_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    t_cur   = gamma_start ? '0 : t_q;
    last    = 1'b0;
    if (gamma_start) begin
      // Restart from any state; the gamma_start cycle itself is offset 0.
      state_d = TD_ACTIVE;
      t_d     = VAL_W'(1);
    end else if (state_q == TD_ACTIVE) begin
      if (t_q == LAST_T) begin
        state_d = TD_IDLE;
        t_d     = '0;
        last    = 1'b1;
      end else begin
        t_d = t_q + VAL_W'(1);
      end
    end
  end

  assign busy = (state_q == TD_ACTIVE) || gamma_start;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    temporal_edge_capture #(
      .G       (GAMMA_CYCLE_WIDTH),
      .FALLING (FALLING),
      .VAL_W   (VAL_W)
    ) u_capture (
      .clk   (clk),
      .rst   (rst),
      .clear (gamma_start),
      .t     (t_cur),
      .line  (lines_in[i]),
      .value (result[i*VAL_W +: VAL_W])
    );
  end

  assign hs = out_valid && out_ready;

  // A handshake in the transfer cycle frees the slot, so the new result loads without loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_value   <= '0;
      out_overrun <= 1'b0;
    end else if (last) begin
      if (!out_valid || hs) begin
        out_value <= result;
        out_valid <= 1'b1;
      end else begin
        out_overrun <= 1'b1;
      end
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_temporal_decoder.sv
// Self-checking bench for temporal_decoder: directed windows plus randomized line waveforms
// decoded by a first-edge reference model; a FALLING=1 instance covers inverted polarity.
module tb_temporal_decoder;

  localparam int G  = 16;
  localparam int NL = 4;
  localparam int VW = $clog2(G + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             gamma_start = 1'b0;
  logic [NL-1:0]    lines_in = '0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [NL*VW-1:0] out_value;
  logic             out_overrun;
  logic             busy;

  logic             gs_f = 1'b0;
  logic [NL-1:0]    lines_f = '1;
  logic             ready_f = 1'b0;
  logic             valid_f;
  logic [NL*VW-1:0] value_f;
  logic             overrun_f;
  logic             busy_f;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NL-1:0]    wave [G];
  logic [NL*VW-1:0] exp_a;

  always #5 clk = ~clk;

  temporal_decoder #(.GAMMA_CYCLE_WIDTH(G), .NUM_LINES(NL), .FALLING(1'b0)) dut (
    .clk(clk), .rst(rst), .gamma_start(gamma_start), .lines_in(lines_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_overrun(out_overrun), .busy(busy)
  );

  temporal_decoder #(.GAMMA_CYCLE_WIDTH(G), .NUM_LINES(NL), .FALLING(1'b1)) dut_f (
    .clk(clk), .rst(rst), .gamma_start(gs_f), .lines_in(lines_f),
    .out_valid(valid_f), .out_ready(ready_f), .out_value(value_f),
    .out_overrun(overrun_f), .busy(busy_f)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: per line, the first offset where the line is active after being idle
  // (the sample before t=0 counts as idle); G when there is no such offset.
  function automatic logic [NL*VW-1:0] decode(input logic falling);
    logic [NL*VW-1:0] r;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      int   first;
      logic prev;
      first = G;
      prev  = falling;
      for (int t = 0; t < G; t++) begin
        if (first == G && wave[t][i] != falling && prev == falling) first = t;
        prev = wave[t][i];
      end
      r[i*VW +: VW] = VW'(first);
    end
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < NL; i++) begin
      int unsigned mode, st;
      mode = $urandom_range(0, 3);
      st   = $urandom_range(0, G - 1);
      for (int t = 0; t < G; t++) begin
        case (mode)
          0:       wave[t][i] = 1'b0;
          1:       wave[t][i] = (t >= int'(st));
          default: wave[t][i] = 1'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  task automatic cyc(input logic gs, input logic [NL-1:0] ln);
    gamma_start = gs;
    lines_in    = ln;
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input bit expect_empty, input bit ready_last);
    for (int t = 0; t < G; t++) begin
      gamma_start = (t == 0);
      lines_in    = wave[t];
      if (ready_last && t == G - 1) out_ready = 1'b1;
      #1;
      if (t == 0 || t == G / 2) check("busy_in_window", busy, 1);
      if (expect_empty && t >= 1) check("no_early_valid", out_valid, 0);
      @(posedge clk);
      #1;
    end
    gamma_start = 1'b0;
    if (ready_last) out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_value", out_value, 0);
    check("rst_overrun", out_overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_valid_f", valid_f, 0);
    rst = 1'b0;
    cyc(0, '0);

    // Directed: line0 @3, line1 @0, line2 never, line3 @15
    for (int t = 0; t < G; t++)
      wave[t] = {t == G - 1, 1'b0, 1'b1, t >= 3};
    run_window(1, 0);
    check("dir_valid", out_valid, 1);
    check("dir_value", out_value, {5'd15, 5'd16, 5'd0, 5'd3});
    check("dir_model", out_value, decode(0));
    out_ready = 1'b1;
    cyc(0, '0);
    check("dir_drained", out_valid, 0);
    out_ready = 1'b0;

    // First edge only: rise @2, fall @4, rise @6
    for (int t = 0; t < G; t++)
      wave[t] = {3'b000, (t == 2 || t == 3 || t >= 6)};
    run_window(1, 0);
    check("glitch_line0", out_value[VW-1:0], 2);
    check("glitch_model", out_value, decode(0));
    out_ready = 1'b1;
    cyc(0, '0);
    out_ready = 1'b0;

    // Falling polarity: line1 falls @7, others stay high
    for (int t = 0; t < G; t++) begin
      gs_f    = (t == 0);
      lines_f = (t >= 7) ? 4'b1101 : 4'b1111;
      @(posedge clk);
      #1;
    end
    gs_f    = 1'b0;
    lines_f = '1;
    check("fall_valid", valid_f, 1);
    check("fall_value", value_f, {5'd16, 5'd16, 5'd7, 5'd16});

    // Back-to-back random windows, consumer always ready
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      fill_random();
      run_window(1, 0);
      check("b2b_valid", out_valid, 1);
      check("b2b_value", out_value, decode(0));
      check("b2b_overrun", out_overrun, 0);
    end
    cyc(0, '0);
    out_ready = 1'b0;

    // Ready pulsed exactly in the transfer cycle of the following window
    fill_random();
    run_window(1, 0);
    check("pulse_first", out_value, decode(0));
    fill_random();
    run_window(0, 1);
    check("pulse_valid", out_valid, 1);
    check("pulse_value", out_value, decode(0));
    check("pulse_overrun", out_overrun, 0);
    out_ready = 1'b1;
    cyc(0, '0);
    out_ready = 1'b0;

    // Overrun: two windows complete with no consumer
    fill_random();
    run_window(1, 0);
    exp_a = decode(0);
    check("ovr_first", out_value, exp_a);
    fill_random();
    run_window(0, 0);
    check("ovr_valid", out_valid, 1);
    check("ovr_kept", out_value, exp_a);
    check("ovr_flag", out_overrun, 1);
    out_ready = 1'b1;
    cyc(0, '0);
    check("ovr_drained", out_valid, 0);
    check("ovr_sticky", out_overrun, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("ovr_rst", out_overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Restart: second gamma_start at t=5 discards the partial window
    for (int t = 0; t < 5; t++)
      cyc(t == 0, NL'($urandom_range(0, 15)));
    fill_random();
    run_window(1, 0);
    check("restart_valid", out_valid, 1);
    check("restart_value", out_value, decode(0));

    // Reset at t=9 with a result pending
    for (int t = 0; t < 9; t++)
      cyc(t == 0, NL'($urandom_range(0, 15)));
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_value", out_value, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", out_overrun, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 20; t++) begin
      cyc(0, NL'($urandom_range(0, 15)));
      check("postrst_valid", out_valid, 0);
    end
    check("postrst_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
